set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache with one data word per line. It sits between the processor's data-memory port and the main data memory. Tag compare, victim selection and miss handling are done by an internal FSM that talks to memory over a req/ack handshake. It generalises the team's fixed 2-way, 8-set, 8-bit cache to arbitrary ways, sets and widths, and adds round-robin replacement and memory back-pressure.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/cache_victim_sel.sv | 28 ++
 rtl/set_assoc_cache.sv | 235 +++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM states, width helpers, line layout.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WB     = 2'd2,
        ST_FILL   = 2'd3
    } state_t;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    function automatic int rr_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Line layout, LSB first: data, tag, dirty, valid.
    localparam int LINE_DATA_LSB = 0;

    function automatic int line_tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int line_dirty_bit(input int data_w, input int tag_w);
        return data_w + tag_w;
    endfunction

    function automatic int line_valid_bit(input int data_w, input int tag_w);
        return data_w + tag_w + 1;
    endfunction

    function automatic int line_width(input int data_w, input int tag_w);
        return data_w + tag_w + 2;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim chooser: lowest-index invalid way, else the round-robin way.
// Latency: combinational.
// Backpressure: none.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int RR_W = rr_width(WAYS)
) (
    input  logic [WAYS-1:0] valid,
    input  logic [RR_W-1:0] rr,
    output logic [RR_W-1:0] victim,
    output logic            used_rr
);

    // Scan downwards so the lowest invalid way is the last one to win.
    always_comb begin
        victim  = rr;
        used_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim  = RR_W'(w);
                used_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way write-back, write-allocate cache, one word per line, round-robin replacement.
// Latency: hit done 2 cycles after accept; misses add one req/ack phase per memory access.
// Backpressure: cpu_ready low outside IDLE; memory request held stable until mem_ack.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3,
    parameter int WAYS    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_W     = tag_width(ADDR_W, INDEX_W);
    localparam int RR_W      = rr_width(WAYS);
    localparam int SETS      = 1 << INDEX_W;
    localparam int LINE_W    = line_width(DATA_W, TAG_W);
    localparam int TAG_LSB   = line_tag_lsb(DATA_W);
    localparam int DIRTY_BIT = line_dirty_bit(DATA_W, TAG_W);
    localparam int VALID_BIT = line_valid_bit(DATA_W, TAG_W);

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q [SETS][WAYS];
    logic [LINE_W-1:0]   line_d [SETS][WAYS];
    logic [RR_W-1:0]     rr_q   [SETS];
    logic [RR_W-1:0]     rr_d   [SETS];
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [RR_W-1:0]     vic_q, vic_d;
    logic                cpu_done_q, cpu_done_d;
    logic                cpu_hit_q, cpu_hit_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [WAYS-1:0]     valid_vec;
    logic                hit;
    logic [RR_W-1:0]     hit_way;
    logic [RR_W-1:0]     victim;
    logic                used_rr;
    logic [LINE_W-1:0]   wr_line;
    logic [LINE_W-1:0]   fill_line;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];

    // Tag compare across the ways of the addressed set.
    always_comb begin
        valid_vec = '0;
        hit       = 1'b0;
        hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = line_q[idx][w][VALID_BIT];
            if (line_q[idx][w][VALID_BIT] && (line_q[idx][w][TAG_LSB +: TAG_W] == tag)) begin
                hit     = 1'b1;
                hit_way = RR_W'(w);
            end
        end
    end

    cache_victim_sel #(.WAYS(WAYS), .RR_W(RR_W)) u_victim_sel (
        .valid   (valid_vec),
        .rr      (rr_q[idx]),
        .victim  (victim),
        .used_rr (used_rr)
    );

    // Candidate lines for installing a write (dirty) or a fill (clean).
    always_comb begin
        wr_line                                = '0;
        wr_line[VALID_BIT]                     = 1'b1;
        wr_line[DIRTY_BIT]                     = 1'b1;
        wr_line[TAG_LSB +: TAG_W]              = tag;
        wr_line[LINE_DATA_LSB +: DATA_W]       = wdata_q;
        fill_line                              = '0;
        fill_line[VALID_BIT]                   = 1'b1;
        fill_line[TAG_LSB +: TAG_W]            = tag;
        fill_line[LINE_DATA_LSB +: DATA_W]     = mem_rdata;
    end

    // Controller: lookup, victim write-back, fill, completion.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        vic_d       = vic_q;
        cpu_done_d  = 1'b0;
        cpu_hit_d   = cpu_hit_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    if (we_q) line_d[idx][hit_way] = wr_line;
                    else      cpu_rdata_d = line_q[idx][hit_way][LINE_DATA_LSB +: DATA_W];
                    cpu_done_d = 1'b1;
                    cpu_hit_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    vic_d = victim;
                    if (used_rr) rr_d[idx] = rr_q[idx] + RR_W'(1);
                    if (line_q[idx][victim][VALID_BIT] && line_q[idx][victim][DIRTY_BIT]) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {line_q[idx][victim][TAG_LSB +: TAG_W], idx};
                        mem_wdata_d = line_q[idx][victim][LINE_DATA_LSB +: DATA_W];
                        state_d     = ST_WB;
                    end else if (!we_q) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        state_d    = ST_FILL;
                    end else begin
                        line_d[idx][victim] = wr_line;
                        cpu_done_d = 1'b1;
                        cpu_hit_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                if (mem_req_q && mem_ack) begin
                    mem_req_d = 1'b0;
                    line_d[idx][vic_q][VALID_BIT] = 1'b0;
                    if (we_q) begin
                        line_d[idx][vic_q] = wr_line;
                        cpu_done_d = 1'b1;
                        cpu_hit_d  = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // Entering from WB, the request is raised one cycle late to leave a gap.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (mem_ack) begin
                    mem_req_d          = 1'b0;
                    line_d[idx][vic_q] = fill_line;
                    cpu_rdata_d        = mem_rdata;
                    cpu_done_d         = 1'b1;
                    cpu_hit_d          = 1'b0;
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and storage registers; reset abandons any outstanding work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) line_q[s][w] <= '0;
            end
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            vic_q       <= '0;
            cpu_done_q  <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            vic_q       <= vic_d;
            cpu_done_q  <= cpu_done_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready = (state_q == ST_IDLE) && !reset;
    assign cpu_done  = cpu_done_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: memory responder with programmable ack delay.
module tb_set_assoc_cache;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 3;
    localparam int WAYS    = 2;
    localparam int SETS    = 8;
    localparam int NADDR   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ready, cpu_done, cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    set_assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ack_delay = 0;

    // Backing memory and the value each address should currently read as.
    logic [DATA_W-1:0] mem  [NADDR];
    logic [DATA_W-1:0] gold [NADDR];

    // Reference cache contents.
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    logic [7:0]  m_data  [SETS][WAYS];
    int          m_rr    [SETS];

    // Memory transactions observed since the last clear.
    int          wb_cnt, fill_cnt;
    logic [5:0]  wb_addr_l, fill_addr_l;
    logic [7:0]  wb_data_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
                m_data[s][w]  = '0;
            end
        end
        // Dirty data held only in the cache is gone; memory is what remains.
        for (int a = 0; a < NADDR; a++) gold[a] = mem[a];
    endtask

    // Memory responder: acks after ack_delay extra cycles, checks request stability.
    initial begin : responder
        int         wait_cnt;
        logic [14:0] first;
        wait_cnt = 0;
        first    = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
            end else if (mem_req) begin
                if (wait_cnt == 0) first = {mem_we, mem_addr, mem_wdata};
                else chk("mem_stable", {17'd0, mem_we, mem_addr, mem_wdata}, {17'd0, first});
                chk("ready_busy", {31'd0, cpu_ready}, 32'd0);
                if (wait_cnt >= ack_delay) begin
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wb_cnt++;
                        wb_addr_l = mem_addr;
                        wb_data_l = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        fill_cnt++;
                        fill_addr_l = mem_addr;
                    end
                    mem_ack = 1'b1;
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One CPU access: predict from the model, run it, compare everything observable.
    task automatic do_txn(input bit we, input logic [5:0] addr, input logic [7:0] wdata, input bit pulse);
        int set, tg, hw, vic, lat, exp_lat;
        bit exp_hit, exp_wb, exp_fill, got;
        logic [5:0] exp_wb_addr;
        logic [7:0] exp_wb_data, exp_rdata;
        set = addr % SETS;
        tg  = addr / SETS;
        hw  = -1;
        exp_wb = 0; exp_fill = 0; exp_wb_addr = '0; exp_wb_data = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == tg) hw = w;
        exp_hit = (hw >= 0);
        if (exp_hit) begin
            if (we) begin
                m_data[set][hw]  = wdata;
                m_dirty[set][hw] = 1;
            end
        end else begin
            vic = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][vic < 0 ? w : w]) vic = w;
            if (vic < 0) begin
                vic = m_rr[set];
                m_rr[set] = (m_rr[set] + 1) % WAYS;
            end
            if (m_valid[set][vic] && m_dirty[set][vic]) begin
                exp_wb      = 1;
                exp_wb_addr = 6'(m_tag[set][vic] * SETS + set);
                exp_wb_data = m_data[set][vic];
            end
            exp_fill = !we;
            m_valid[set][vic] = 1;
            m_tag[set][vic]   = tg;
            m_dirty[set][vic] = we;
            m_data[set][vic]  = we ? wdata : gold[addr];
        end
        if (we) gold[addr] = wdata;
        exp_rdata = gold[addr];
        if (exp_hit || (we && !exp_wb)) exp_lat = 1;
        else if (we || !exp_wb)         exp_lat = 2 + ack_delay;
        else                            exp_lat = 4 + 2 * ack_delay;

        wb_cnt = 0; fill_cnt = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #2;
        cpu_req = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #2;
            lat++;
            if (cpu_done) got = 1;
            else if (pulse) begin
                cpu_req   = !cpu_ready;
                cpu_we    = 1'b1;
                cpu_addr  = addr ^ 6'h38;
                cpu_wdata = 8'hEE;
            end
        end
        cpu_req = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("hit", {31'd0, cpu_hit}, {31'd0, exp_hit});
            if (!we) chk("rdata", {24'd0, cpu_rdata}, {24'd0, exp_rdata});
            chk("latency", lat, exp_lat);
            chk("ready_at_done", {31'd0, cpu_ready}, 32'd1);
            chk("wb_count", wb_cnt, {31'd0, exp_wb});
            if (exp_wb) begin
                chk("wb_addr", {26'd0, wb_addr_l}, {26'd0, exp_wb_addr});
                chk("wb_data", {24'd0, wb_data_l}, {24'd0, exp_wb_data});
            end
            chk("fill_count", fill_cnt, {31'd0, exp_fill});
            if (exp_fill) chk("fill_addr", {26'd0, fill_addr_l}, {26'd0, addr});
            @(posedge clk); #2;
            chk("done_pulse", {31'd0, cpu_done}, 32'd0);
            if (pulse) chk("no_spurious", {31'd0, cpu_ready}, 32'd1);
        end
    endtask

    // Reset arriving in the second cycle of a fill.
    task automatic reset_mid_fill(input logic [5:0] addr);
        bit seen, any_done;
        ack_delay = 10;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        @(posedge clk); #2;
        cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #2;
            if (mem_req) seen = 1;
        end
        chk("rst_fill_req", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, cpu_done}, 32'd0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        reset = 1'b0;
        any_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (cpu_done || mem_req) any_done = 1;
        end
        chk("rst_quiet", {31'd0, any_done}, 32'd0);
        model_reset();
        ack_delay = 0;
    endtask

    initial begin
        for (int a = 0; a < NADDR; a++) mem[a] = 8'($urandom_range(0, 255));
        mem[5] = 8'hA5;
        model_reset();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready0", {31'd0, cpu_ready}, 32'd0);
        chk("rst_done0", {31'd0, cpu_done}, 32'd0);
        chk("rst_hit0", {31'd0, cpu_hit}, 32'd0);
        chk("rst_rdata0", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_memreq0", {31'd0, mem_req}, 32'd0);
        chk("rst_memwe0", {31'd0, mem_we}, 32'd0);
        chk("rst_memaddr0", {26'd0, mem_addr}, 32'd0);
        chk("rst_memwdata0", {24'd0, mem_wdata}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, cpu_ready}, 32'd1);

        ack_delay = 0;
        do_txn(1'b0, 6'h05, 8'h00, 1'b0);   // clean read miss, fill A5
        do_txn(1'b0, 6'h05, 8'h00, 1'b0);   // hit A5
        do_txn(1'b1, 6'h0D, 8'h3C, 1'b0);   // write miss into free way
        do_txn(1'b0, 6'h0D, 8'h00, 1'b0);   // hit 3C
        do_txn(1'b1, 6'h15, 8'h77, 1'b0);   // clean eviction of way0
        do_txn(1'b1, 6'h1D, 8'h99, 1'b0);   // dirty eviction: WB 0x0D/3C, no fill

        ack_delay = 5;
        do_txn(1'b0, 6'h22, 8'h00, 1'b0);   // slow clean fill

        reset_mid_fill(6'h2A);
        do_txn(1'b0, 6'h05, 8'h00, 1'b0);   // misses again after reset

        ack_delay = 2;
        do_txn(1'b1, 6'h03, 8'h11, 1'b0);
        do_txn(1'b1, 6'h0B, 8'h22, 1'b0);
        do_txn(1'b0, 6'h13, 8'h00, 1'b1);   // dirty read miss with stray requests

        for (int n = 0; n < 300; n++) begin
            ack_delay = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 6'($urandom_range(0, NADDR - 1)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
